dvp_pattern_tx: RTL and testbench



---
 rtl/dvp_pkg.sv | 51 +++++
 rtl/dvp_pattern_tx_if.sv | 12 +
 rtl/dvp_pattern_gen.sv | 25 ++
 rtl/dvp_pattern_tx.sv | 141 ++++++++++++++
 tb/tb_dvp_pattern_tx.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dvp_pkg.sv
// Shared encodings, bar colours and frame-geometry helpers for the DVP test-pattern transmitter.
// Pure definitions: no latency and no flow control.
package dvp_pkg;

   typedef enum logic [1:0] {
      PAT_BARS     = 2'd0,
      PAT_GRADIENT = 2'd1,
      PAT_GRID     = 2'd2,
      PAT_FCNT     = 2'd3
   } pattern_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } dvp_state_e;

   localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
   localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
   localparam logic [15:0] BAR_CYAN    = 16'h07FF;
   localparam logic [15:0] BAR_GREEN   = 16'h07E0;
   localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
   localparam logic [15:0] BAR_RED     = 16'hF800;
   localparam logic [15:0] BAR_BLUE    = 16'h001F;
   localparam logic [15:0] BAR_BLACK   = 16'h0000;

   function automatic int line_bytes(input int h_pixel, input int h_blank);
      return 2 * h_pixel + h_blank;
   endfunction

   function automatic int frame_lines(input int v_sync, input int v_bp,
                                      input int v_pixel, input int v_fp);
      return v_sync + v_bp + v_pixel + v_fp;
   endfunction

   function automatic logic [15:0] bar_rgb(input logic [2:0] idx);
      case (idx)
         3'd0:    return BAR_WHITE;
         3'd1:    return BAR_YELLOW;
         3'd2:    return BAR_CYAN;
         3'd3:    return BAR_GREEN;
         3'd4:    return BAR_MAGENTA;
         3'd5:    return BAR_RED;
         3'd6:    return BAR_BLUE;
         default: return BAR_BLACK;
      endcase
   endfunction

   localparam int LINE  = line_bytes(1024, 64);
   localparam int FRAME = frame_lines(2, 4, 768, 4);

endpackage

// File: rtl/dvp_pattern_tx_if.sv
// DVP sensor pins plus frame status; master drives them, slave samples them.
// Plain wires: no latency, no backpressure (the sensor side never stalls).
interface dvp_pattern_tx_if;
   logic        cam_vsync;
   logic        cam_href;
   logic [7:0]  cam_data;
   logic        frame_done;
   logic [15:0] frame_cnt;

   modport master (output cam_vsync, cam_href, cam_data, frame_done, frame_cnt);
   modport slave  (input  cam_vsync, cam_href, cam_data, frame_done, frame_cnt);
endinterface

// File: rtl/dvp_pattern_gen.sv
// Combinational RGB565 pattern map from (pattern, x, y, latched frame count) to one pixel.
// Zero latency; no flow control.
module dvp_pattern_gen
   import dvp_pkg::*;
(
   input  pattern_e    pattern,
   input  logic [2:0]  bar,
   input  logic [5:0]  x,
   input  logic [5:0]  y,
   input  logic [4:0]  fcnt,
   output logic [15:0] pix
);

   always_comb begin
      pix = 16'h0000;
      case (pattern)
         PAT_BARS:     pix = bar_rgb(bar);
         PAT_GRADIENT: pix = {x[4:0], y, x[4:0]};
         PAT_GRID:     pix = (x == 6'd0 || y == 6'd0) ? 16'hFFFF : 16'h0000;
         PAT_FCNT:     pix = {fcnt, x, y[4:0]};
         default:      pix = 16'h0000;
      endcase
   end

endmodule

// File: rtl/dvp_pattern_tx.sv
// OV5640-style DVP transmitter: vsync/href/RGB565 bytes registered one cycle after the h/v counters.
// Free-running source, no backpressure; enable and pattern_sel only take effect at frame start.
module dvp_pattern_tx
   import dvp_pkg::*;
#(
   parameter int H_PIXEL = 1024,
   parameter int V_PIXEL = 768,
   parameter int H_BLANK = 64,
   parameter int V_SYNC  = 2,
   parameter int V_BP    = 4,
   parameter int V_FP    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [1:0]       pattern_sel,
   dvp_pattern_tx_if.master cam
);

   localparam int LINE_LEN  = line_bytes(H_PIXEL, H_BLANK);
   localparam int FRAME_LEN = frame_lines(V_SYNC, V_BP, V_PIXEL, V_FP);
   localparam int HCW       = $clog2(LINE_LEN);
   localparam int VCW       = $clog2(FRAME_LEN);
   localparam int XW        = $clog2(H_PIXEL);
   localparam int ACT_START = V_SYNC + V_BP;
   localparam int ACT_END   = ACT_START + V_PIXEL;

   dvp_state_e     state, state_nxt;
   logic [HCW-1:0] h_cnt, h_nxt;
   logic [VCW-1:0] v_cnt, v_nxt;
   pattern_e       sel_q, sel_nxt;
   logic [4:0]     fcnt_lat, fcnt_nxt;
   logic [15:0]    frame_cnt_q;
   logic           vsync_q, href_q, done_q;
   logic [7:0]     data_q;

   logic           line_end, frame_end, run;
   logic           vsync_c, href_c, done_c;
   logic [7:0]     byte_c;
   logic [5:0]     x_lo, y_lo;
   logic [2:0]     bar;
   logic [15:0]    pix;

   assign line_end  = (h_cnt == HCW'(LINE_LEN - 1));
   assign frame_end = line_end && (v_cnt == VCW'(FRAME_LEN - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      h_nxt     = h_cnt;
      v_nxt     = v_cnt;
      sel_nxt   = sel_q;
      fcnt_nxt  = fcnt_lat;
      case (state)
         ST_IDLE: begin
            h_nxt = '0;
            v_nxt = '0;
            if (enable) begin
               state_nxt = ST_RUN;
               sel_nxt   = pattern_e'(pattern_sel);
               fcnt_nxt  = frame_cnt_q[4:0];
            end
         end
         ST_RUN: begin
            if (!line_end) begin
               h_nxt = h_cnt + HCW'(1);
            end else begin
               h_nxt = '0;
               if (!frame_end) begin
                  v_nxt = v_cnt + VCW'(1);
               end else begin
                  v_nxt = '0;
                  if (enable) begin
                     sel_nxt  = pattern_e'(pattern_sel);
                     fcnt_nxt = frame_cnt_q[4:0];
                  end else begin
                     state_nxt = ST_IDLE;
                  end
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Pixel coordinates; x/y are cut down to the bits any pattern consumes.
   assign run    = (state == ST_RUN);
   assign x_lo   = 6'(h_cnt >> 1);
   assign bar    = 3'(h_cnt >> (XW - 2));
   assign y_lo   = 6'(int'(v_cnt) - ACT_START);
   assign vsync_c = run && (int'(v_cnt) < V_SYNC);
   assign href_c  = run && (int'(v_cnt) >= ACT_START) && (int'(v_cnt) < ACT_END)
                    && (int'(h_cnt) < 2 * H_PIXEL);
   // First blank byte of the last active line: its registered copy lands just after the final byte.
   assign done_c  = run && (int'(v_cnt) == ACT_END - 1) && (int'(h_cnt) == 2 * H_PIXEL);
   assign byte_c  = !href_c ? 8'h00 : (h_cnt[0] ? pix[7:0] : pix[15:8]);

   dvp_pattern_gen u_gen (
      .pattern (sel_q),
      .bar     (bar),
      .x       (x_lo),
      .y       (y_lo),
      .fcnt    (fcnt_lat),
      .pix     (pix)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt       <= '0;
         v_cnt       <= '0;
         sel_q       <= PAT_BARS;
         fcnt_lat    <= '0;
         frame_cnt_q <= '0;
         vsync_q     <= 1'b0;
         href_q      <= 1'b0;
         data_q      <= 8'h00;
         done_q      <= 1'b0;
      end else begin
         h_cnt    <= h_nxt;
         v_cnt    <= v_nxt;
         sel_q    <= sel_nxt;
         fcnt_lat <= fcnt_nxt;
         vsync_q  <= vsync_c;
         href_q   <= href_c;
         data_q   <= byte_c;
         done_q   <= done_c;
         if (done_c) frame_cnt_q <= frame_cnt_q + 16'd1;
      end
   end

   assign cam.cam_vsync  = vsync_q;
   assign cam.cam_href   = href_q;
   assign cam.cam_data   = data_q;
   assign cam.frame_done = done_q;
   assign cam.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_dvp_pattern_tx.sv
// Scoreboard bench for dvp_pattern_tx on a 8x4 frame (LINE=20 bytes, FRAME=7 lines).
module tb_dvp_pattern_tx;

   localparam int H_PIXEL = 8;
   localparam int V_PIXEL = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic [1:0] pattern_sel;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   logic [7:0]  exp_q[$];
   logic [15:0] exp_fc_q[$];
   int          done_cyc_q[$];
   logic [7:0]  first_byte_q[$];
   logic [15:0] fc_model;
   logic        arm = 1'b0;
   logic        prev_done = 1'b0;

   dvp_pattern_tx_if cam_if ();

   dvp_pattern_tx #(
      .H_PIXEL(8), .V_PIXEL(4), .H_BLANK(4), .V_SYNC(1), .V_BP(1), .V_FP(1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .pattern_sel (pattern_sel),
      .cam         (cam_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Hand-derived RGB565 values for the 8-pixel-wide test frame.
   function automatic logic [15:0] model_pix(input logic [1:0] sel, input int x, input int y,
                                             input logic [15:0] fc);
      logic [5:0] xs;
      logic [5:0] ys;
      xs = 6'(x);
      ys = 6'(y);
      case (sel)
         2'd0: begin
            case (x)
               0: return 16'hFFFF;
               1: return 16'hFFE0;
               2: return 16'h07FF;
               3: return 16'h07E0;
               4: return 16'hF81F;
               5: return 16'hF800;
               6: return 16'h001F;
               default: return 16'h0000;
            endcase
         end
         2'd1:    return {xs[4:0], ys, xs[4:0]};
         2'd2:    return (x == 0 || y == 0) ? 16'hFFFF : 16'h0000;
         default: return {fc[4:0], xs, ys[4:0]};
      endcase
   endfunction

   task automatic push_frame(input logic [1:0] sel);
      logic [15:0] p;
      for (int y = 0; y < V_PIXEL; y++) begin
         for (int x = 0; x < H_PIXEL; x++) begin
            p = model_pix(sel, x, y, fc_model);
            exp_q.push_back(p[15:8]);
            exp_q.push_back(p[7:0]);
         end
      end
      fc_model = fc_model + 16'd1;
      exp_fc_q.push_back(fc_model);
   endtask

   // Monitor: pops expected bytes whenever href is high, checks blanking and frame_done.
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (cam_if.cam_href) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_byte: got %h, expected no href", cam_if.cam_data);
            end else begin
               e = exp_q.pop_front();
               chk("href_byte", 16'(cam_if.cam_data), 16'(e));
            end
            if (arm) begin
               first_byte_q.push_back(cam_if.cam_data);
               arm = 1'b0;
            end
            chk("href_during_vsync", 16'(cam_if.cam_vsync), 16'h0);
         end else begin
            chk("blank_data", 16'(cam_if.cam_data), 16'h0);
         end
         if (cam_if.cam_vsync) arm = 1'b1;
         if (cam_if.frame_done) begin
            chk("done_width", 16'(prev_done), 16'h0);
            done_cyc_q.push_back(cyc);
            if (exp_fc_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_done: got frame_cnt %h, expected no frame_done",
                        cam_if.frame_cnt);
            end else begin
               chk("frame_cnt", cam_if.frame_cnt, exp_fc_q.pop_front());
            end
         end
         prev_done = cam_if.frame_done;
      end
   end

   task automatic wait_done(input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!cam_if.frame_done && n < budget);
      if (!cam_if.frame_done) begin
         tests++;
         fails++;
         $display("FAIL wait_done: got no frame_done, expected one within %0d cycles", budget);
      end
   endtask

   // Call right after enabling from IDLE at a negedge; k=0 is the first sample after RUN entry.
   task automatic check_frame_start();
      int first_v = -1;
      int first_h = -1;
      int v_hi = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (cam_if.cam_vsync) begin
            v_hi++;
            if (first_v < 0) first_v = k;
         end
         if (cam_if.cam_href && first_h < 0) first_h = k;
      end
      chk("vsync_start", 16'(first_v), 16'd1);
      chk("vsync_len", 16'(v_hi), 16'd20);
      chk("href_start", 16'(first_h), 16'd41);
   endtask

   task automatic idle_check(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("idle_vsync", 16'(cam_if.cam_vsync), 16'h0);
         chk("idle_href", 16'(cam_if.cam_href), 16'h0);
         chk("idle_data", 16'(cam_if.cam_data), 16'h0);
      end
   endtask

   initial begin
      #100000;
      fails++;
      $display("FAIL watchdog: got timeout, expected run to complete");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n = 1'b0;
      enable = 1'b0;
      pattern_sel = 2'd0;
      fc_model = 16'h0;
      repeat (3) @(negedge clk);
      chk("rst_vsync", 16'(cam_if.cam_vsync), 16'h0);
      chk("rst_href", 16'(cam_if.cam_href), 16'h0);
      chk("rst_data", 16'(cam_if.cam_data), 16'h0);
      chk("rst_done", 16'(cam_if.frame_done), 16'h0);
      chk("rst_fcnt", cam_if.frame_cnt, 16'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Colour bars, one frame, with vsync/href start timing.
      push_frame(2'd0);
      pattern_sel = 2'd0;
      enable = 1'b1;
      check_frame_start();
      enable = 1'b0;
      wait_done(200);
      repeat (30) @(negedge clk);
      idle_check(5);

      // Grid frame.
      push_frame(2'd2);
      pattern_sel = 2'd2;
      enable = 1'b1;
      @(negedge clk);
      enable = 1'b0;
      wait_done(200);
      repeat (30) @(negedge clk);

      // Three frame-counter-fill frames back to back after a fresh reset.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      fc_model = 16'h0;
      push_frame(2'd3);
      push_frame(2'd3);
      push_frame(2'd3);
      done_cyc_q.delete();
      first_byte_q.delete();
      pattern_sel = 2'd3;
      enable = 1'b1;
      wait_done(200);
      wait_done(200);
      repeat (30) @(negedge clk);
      enable = 1'b0;
      wait_done(200);
      repeat (30) @(negedge clk);
      chk("done_count", 16'(done_cyc_q.size()), 16'd3);
      if (done_cyc_q.size() == 3) begin
         chk("done_gap1", 16'(done_cyc_q[1] - done_cyc_q[0]), 16'd140);
         chk("done_gap2", 16'(done_cyc_q[2] - done_cyc_q[1]), 16'd140);
      end
      chk("first_byte_count", 16'(first_byte_q.size()), 16'd3);
      if (first_byte_q.size() == 3) begin
         chk("f1_first_byte", 16'(first_byte_q[0]), 16'h00);
         chk("f2_first_byte", 16'(first_byte_q[1]), 16'h08);
         chk("f3_first_byte", 16'(first_byte_q[2]), 16'h10);
      end

      // Mid-frame enable drop and pattern switch: frame finishes as bars, then gradient.
      push_frame(2'd0);
      pattern_sel = 2'd0;
      enable = 1'b1;
      @(negedge clk);
      repeat (60) @(negedge clk);
      pattern_sel = 2'd1;
      enable = 1'b0;
      wait_done(200);
      repeat (30) @(negedge clk);
      idle_check(5);
      push_frame(2'd1);
      enable = 1'b1;
      @(negedge clk);
      enable = 1'b0;
      wait_done(200);
      repeat (30) @(negedge clk);

      // Asynchronous reset while href is high, then a clean restart.
      push_frame(2'd2);
      pattern_sel = 2'd2;
      enable = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!cam_if.cam_href && n < 100);
      chk("href_before_reset", 16'(cam_if.cam_href), 16'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_vsync", 16'(cam_if.cam_vsync), 16'h0);
      chk("arst_href", 16'(cam_if.cam_href), 16'h0);
      chk("arst_data", 16'(cam_if.cam_data), 16'h0);
      chk("arst_done", 16'(cam_if.frame_done), 16'h0);
      chk("arst_fcnt", cam_if.frame_cnt, 16'h0);
      exp_q.delete();
      exp_fc_q.delete();
      fc_model = 16'h0;
      push_frame(2'd2);
      @(negedge clk);
      rst_n = 1'b1;
      check_frame_start();
      enable = 1'b0;
      wait_done(200);
      repeat (30) @(negedge clk);

      // frame_cnt wrap from 0xFFFF.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      force dut.frame_cnt_q = 16'hFFFF;
      @(negedge clk);
      release dut.frame_cnt_q;
      @(negedge clk);
      chk("fcnt_preload", cam_if.frame_cnt, 16'hFFFF);
      fc_model = 16'hFFFF;
      push_frame(2'd3);
      pattern_sel = 2'd3;
      enable = 1'b1;
      @(negedge clk);
      enable = 1'b0;
      wait_done(200);
      repeat (30) @(negedge clk);
      chk("fcnt_wrap", cam_if.frame_cnt, 16'h0000);

      chk("bytes_left", 16'(exp_q.size()), 16'h0);
      chk("frames_left", 16'(exp_fc_q.size()), 16'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
